// File: rtl/apb_pkg.sv
// apb_pkg: types and default widths shared by the APB blocks.
// Holds the initiator state encoding and the command/response record layouts.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

    // Initiator FSM: one APB transfer in flight at most.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Command record at the default widths (for blocks that pass commands around).
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

    // Response record at the default widths.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command stream, response stream and APB bus of one initiator.
// The master modport is the initiator's view; slave is the view of everything
// around it (command source, response sink and the APB peripheral).
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int unsigned PADDR_SIZE = APB_ADDR_W,
    parameter int unsigned PDATA_SIZE = APB_DATA_W
);
    localparam int unsigned PSTRB_SIZE = PDATA_SIZE / 8;

    // Command stream
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [PADDR_SIZE-1:0] cmd_addr;
    logic [PDATA_SIZE-1:0] cmd_wdata;
    logic [PSTRB_SIZE-1:0] cmd_strb;

    // Response stream
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [PDATA_SIZE-1:0] rsp_rdata;
    logic                  rsp_err;

    // APB bus
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic [PDATA_SIZE-1:0] PWDATA;
    logic [PSTRB_SIZE-1:0] PSTRB;
    logic [PDATA_SIZE-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts APB wait states of the current access phase.
// clear restarts the count; expired is raised during the wait cycle that
// brings the count up to LIMIT, so the access ends after exactly LIMIT
// wait cycles.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    // The count only ever holds 0..LIMIT-1; the LIMIT-th wait ends the access.
    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    // Terminal wait cycle and next count value.
    always_comb begin
        expired = enable && (count_q == CNT_W'(LIMIT - 1));
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB4 initiator.
// Turns a valid/ready command stream into APB setup/access transfers and
// returns read data plus error status on a valid/ready response stream.
// Optional feature macro: APB_MASTER_TIMEOUT_EN abandons an access after
// TIMEOUT_CYCLES wait states and reports it as an error response.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned PADDR_SIZE     = APB_ADDR_W,
    parameter int unsigned PDATA_SIZE     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    localparam int unsigned PSTRB_SIZE = PDATA_SIZE / 8;

    apb_state_e            state_q,  state_d;
    logic [PADDR_SIZE-1:0] paddr_q,  paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
    logic [PSTRB_SIZE-1:0] pstrb_q,  pstrb_d;
    logic [PDATA_SIZE-1:0] rdata_q,  rdata_d;
    logic                  err_q,    err_d;
    logic                  timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    // Wait-state limit: restarted in SETUP, counts ACCESS cycles with PREADY low.
    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (state_q == SETUP),
        .enable  ((state_q == ACCESS) && !bus.PREADY),
        .expired (timeout_hit)
    );
`else
    // Without the limit an access waits for PREADY forever.
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES only has meaning when the limit is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state and next-value logic for the transfer sequencer.
    always_comb begin
        // NOTE: every _d starts from its held value, so no branch can leave one
        // unassigned and infer a latch.
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    // Reads drive no data and no strobes.
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY on the terminal wait cycle still completes normally.
                if (bus.PREADY) begin
                    rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    err_d   = bus.PSLVERR;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge PCLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Handshake and APB controls decode straight from the registered state.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.rsp_valid = (state_q == RESP);

    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master with a small GPIO slave stub.
// Table of transfers plus hand-written sequences for back-pressure, reset in
// ACCESS and the wait-state limit (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4).
module tb_apb_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    apb_master_if #(.PADDR_SIZE(AW), .PDATA_SIZE(DW)) bus ();

    apb_master #(
        .PADDR_SIZE     (AW),
        .PDATA_SIZE     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- GPIO slave stub ----------------
    // Wait states and error are configured per transfer; while not completing,
    // PSLVERR is driven high and PRDATA with junk so stray sampling shows up.
    logic [31:0] gpio_mem [4];
    int          stall_cfg = 0;
    logic        err_cfg   = 1'b0;
    int          wait_left = 0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) gpio_mem[i] = 32'h0;
        end
        if (bus.PSEL && !bus.PENABLE) wait_left = stall_cfg;
        if (bus.PSEL && bus.PENABLE && wait_left == 0) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = err_cfg;
            if (bus.PWRITE) begin
                bus.PRDATA = 32'hDEAD_0000;
                for (int b = 0; b < 4; b++)
                    if (bus.PSTRB[b]) gpio_mem[bus.PADDR[1:0]][8*b +: 8] = bus.PWDATA[8*b +: 8];
            end else begin
                bus.PRDATA = gpio_mem[bus.PADDR[1:0]];
            end
        end else begin
            if (bus.PSEL && bus.PENABLE) wait_left--;
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b1;
            bus.PRDATA  = 32'hBAD0_BAD0;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          stall;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // cycle of rsp_valid, acceptance edge = N
    } vec_t;

    vec_t vecs [9];

    // Runs one transfer with rsp_ready high and checks setup, access, response.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int acc;
        bit got;
        stall_cfg = v.stall;
        err_cfg   = v.slverr;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_strb  = v.strb;
        #1 check($sformatf("v%0d_cmd_ready_idle", idx), bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'hFFFF_FFFF;
        bus.cmd_wdata = 32'h5555_5555;
        bus.cmd_strb  = 4'hF;
        check($sformatf("v%0d_setup_ctrl", idx), {bus.PSEL, bus.PENABLE, bus.cmd_ready}, 3'b100);
        check($sformatf("v%0d_setup_bus", idx),
              {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PWRITE},
              {v.addr, (v.wr ? v.wdata : 32'h0), (v.wr ? v.strb : 4'h0), v.wr});
        cyc = 0; acc = 0; got = 0;
        while (!got && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rsp_valid) begin
                got = 1;
            end else if (bus.PSEL && bus.PENABLE) begin
                acc++;
                check($sformatf("v%0d_access_bus", idx),
                      {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PWRITE},
                      {v.addr, (v.wr ? v.wdata : 32'h0), (v.wr ? v.strb : 4'h0), v.wr});
            end
        end
        check($sformatf("v%0d_latency", idx), cyc + 1, v.exp_lat);
        check($sformatf("v%0d_access_cycles", idx), acc, v.stall + 1);
        check($sformatf("v%0d_rsp", idx), {bus.rsp_rdata, bus.rsp_err}, {v.exp_rdata, v.exp_err});
        check($sformatf("v%0d_resp_ctrl", idx), {bus.PSEL, bus.PENABLE, bus.cmd_ready}, 3'b000);
        @(posedge clk); #1;
        check($sformatf("v%0d_back_idle", idx), {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    // Waits (bounded) for rsp_valid; returns cycles waited and whether it came.
    task automatic wait_rsp(input int budget, output int cyc, output bit got);
        cyc = 0; got = 0;
        while (!got && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rsp_valid) got = 1;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int acc;
        bit got;
        int seen;

        //        wr    addr    wdata          strb stall err  exp_rdata      err  lat
        vecs[0] = '{1'b1, 32'h1, 32'h0000_00FF, 4'hF, 0, 1'b0, 32'h0000_0000, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0000_00FF, 1'b0, 3};
        vecs[2] = '{1'b1, 32'h2, 32'h1234_5678, 4'h5, 0, 1'b0, 32'h0000_0000, 1'b0, 3};
        vecs[3] = '{1'b0, 32'h2, 32'h0000_0000, 4'h0, 0, 1'b0, 32'h0034_0078, 1'b0, 3};
        vecs[4] = '{1'b0, 32'h1, 32'h0000_0000, 4'h0, 3, 1'b1, 32'h0000_00FF, 1'b1, 6};
        vecs[5] = '{1'b1, 32'h3, 32'hA5A5_A5A5, 4'hF, 1, 1'b0, 32'h0000_0000, 1'b0, 4};
        vecs[6] = '{1'b0, 32'h3, 32'h0000_0000, 4'h0, 0, 1'b0, 32'hA5A5_A5A5, 1'b0, 3};
        vecs[7] = '{1'b1, 32'h1, 32'h0000_AB00, 4'h2, 2, 1'b1, 32'h0000_0000, 1'b1, 5};
        vecs[8] = '{1'b0, 32'h1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0000_ABFF, 1'b0, 3};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.cmd_ready}, 6'b000001);
        check("reset_data", {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.rsp_rdata}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("cmd_ready_after_reset", bus.cmd_ready, 1);

        // ---- table-driven transfers ----
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // ---- response back-pressure with a second command waiting ----
        stall_cfg = 0; err_cfg = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h3;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0000_0011;
        bus.cmd_strb  = 4'hF;
        wait_rsp(10, cyc, got);
        check("bp_rsp_arrives", got, 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold_%0d", k),
                  {bus.rsp_valid, bus.rsp_rdata, bus.cmd_ready, bus.PSEL},
                  {1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0});
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_idle", {bus.rsp_valid, bus.cmd_ready, bus.PSEL}, 3'b010);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("bp_second_setup", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
              {3'b101, 32'h0, 32'h0000_0011});
        wait_rsp(10, cyc, got);
        check("bp_second_rsp", {got, bus.rsp_rdata, bus.rsp_err}, {1'b1, 32'h0, 1'b0});
        @(posedge clk); #1;

        // ---- reset asserted during ACCESS ----
        stall_cfg = 10;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_in_access_reached", {bus.PSEL, bus.PENABLE}, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_access_outputs", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.PADDR}, '0);
        @(negedge clk);
        rst = 1'b0;
        stall_cfg = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        check("rst_no_response", seen, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);

        // ---- PREADY stuck low ----
        stall_cfg = 1000; err_cfg = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h2;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        cyc = 0; acc = 0; got = 0;
        while (!got && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rsp_valid) got = 1;
            else if (bus.PSEL && bus.PENABLE) acc++;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        check("to_rsp_arrives", got, 1);
        check("to_latency", cyc + 1, 6);
        check("to_access_cycles", acc, 4);
        check("to_rsp", {bus.rsp_rdata, bus.rsp_err, bus.PSEL, bus.PENABLE}, {32'h0, 3'b100});
        @(posedge clk); #1;
        check("to_back_idle", bus.cmd_ready, 1);
`else
        check("no_to_no_rsp", got, 0);
        check("no_to_still_access", {bus.PSEL, bus.PENABLE, acc}, {2'b11, 32'd30});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("no_to_recovered", {bus.cmd_ready, bus.PSEL}, 2'b10);
`endif
        stall_cfg = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
